// File: rtl/misao_core.sv
// MISA-O nibble-serial accumulator CPU: 3-cycle FETCH/WAIT/EXEC per nibble, byte-wide memory port.
// Optional `MISAO_WFI_EN: extended WFI halts the core until reset (otherwise WFI is a NOP).
module misao_core #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_enable_read,
    output logic        mem_enable_write,
    input  logic [7:0]  mem_data_in,
    output logic [14:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_data_out,
    output logic [15:0] test_data
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
`ifdef MISAO_WFI_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    // Base page
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_CC   = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1101;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b1011;
    localparam logic [3:0] OP_BEQZ = 4'b0111;
    localparam logic [3:0] OP_BTST = 4'b1111;
    localparam logic [3:0] OP_JAL  = 4'b0010;
    localparam logic [3:0] OP_RACC = 4'b0110;
    localparam logic [3:0] OP_RSS  = 4'b1010;
    localparam logic [3:0] OP_SS   = 4'b1110;
    localparam logic [3:0] OP_LDI  = 4'b0100;
    localparam logic [3:0] OP_XMEM = 4'b1100;
    localparam logic [3:0] OP_XOP  = 4'b1000;

    // Extended page shares encodings with its base counterpart; RRS/SIA/RETI/SWI fall to NOP
    localparam logic [3:0] X_CFG = 4'b0001;
    localparam logic [3:0] X_INV = 4'b0101;
    localparam logic [3:0] X_XOR = 4'b1001;
    localparam logic [3:0] X_SHR = 4'b1101;
    localparam logic [3:0] X_SUB = 4'b0011;
    localparam logic [3:0] X_DEC = 4'b1011;
    localparam logic [3:0] X_BC  = 4'b0111;
    localparam logic [3:0] X_TST = 4'b1111;
    localparam logic [3:0] X_JMP = 4'b0010;
    localparam logic [3:0] X_RSA = 4'b1010;
    localparam logic [3:0] X_SA  = 4'b1110;
`ifdef MISAO_WFI_EN
    localparam logic [3:0] X_WFI = 4'b0000;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d, ra_q, ra_d, lr_q, lr_d;
    logic [3:0]  acc_q, acc_d, rs_q, rs_d, cfg_q, cfg_d;
    logic        c_q, c_d, t_q, t_d, xop_q, xop_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  op_q, op_d, hi_q, hi_d;
    logic        opx_q, opx_d;
    logic        rd_q, rd_d, wr_q, wr_d, rw_q, rw_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;

    logic [3:0]  nib;
    logic [15:0] pc_inc, pc_br, pc_jal;
    logic [4:0]  add5, sub5, inc5, dec5;

    assign nib    = pc_q[0] ? mem_data_in[7:4] : mem_data_in[3:0];
    assign pc_inc = pc_q + 16'd1;
    assign pc_br  = pc_inc + {{12{nib[3]}}, nib};
    assign pc_jal = pc_inc + {{8{hi_q[3]}}, hi_q, nib};
    assign add5   = 5'(acc_q) + 5'(rs_q) + 5'(c_q);
    assign sub5   = 5'(acc_q) - 5'(rs_q);
    assign inc5   = 5'(acc_q) + 5'd1;
    assign dec5   = 5'(acc_q) - 5'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ra_d    = ra_q;
        lr_d    = lr_q;
        acc_d   = acc_q;
        rs_d    = rs_q;
        cfg_d   = cfg_q;
        c_d     = c_q;
        t_d     = t_q;
        xop_d   = xop_q;
        phase_d = phase_q;
        op_d    = op_q;
        opx_d   = opx_q;
        hi_d    = hi_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        rw_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;

        case (state_q)
            S_FETCH: begin
                rd_d    = 1'b1;
                addr_d  = pc_q[15:1];
                state_d = S_WAIT;
            end
            S_WAIT: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (phase_q == 2'd0) begin
                    if (!xop_q) begin
                        case (nib)
                            OP_NOP:  ;
                            OP_CC:   c_d = 1'b0;
                            OP_AND:  acc_d = acc_q & rs_q;
                            OP_OR:   acc_d = acc_q | rs_q;
                            OP_SHL:  begin c_d = acc_q[3]; acc_d = {acc_q[2:0], 1'b0}; end
                            OP_ADD:  begin c_d = add5[4]; acc_d = add5[3:0]; end
                            OP_INC:  begin c_d = inc5[4]; acc_d = inc5[3:0]; end
                            OP_BEQZ, OP_BTST, OP_JAL, OP_LDI: begin
                                op_d = nib; opx_d = 1'b0; phase_d = 2'd1;
                            end
                            OP_RACC: begin acc_d = rs_q; rs_d = acc_q; end
                            OP_RSS:  acc_d = rs_q;
                            OP_SS:   rs_d = acc_q;
                            OP_XMEM: begin
                                state_d = S_STORE;
                                wr_d    = 1'b1;
                                rw_d    = 1'b1;
                                addr_d  = ra_q[15:1];
                                dout_d  = {rs_q, acc_q};
                            end
                            OP_XOP:  xop_d = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        xop_d = 1'b0;
                        case (nib)
                            X_CFG, X_BC: begin op_d = nib; opx_d = 1'b1; phase_d = 2'd1; end
                            X_INV: acc_d = ~acc_q;
                            X_XOR: acc_d = acc_q ^ rs_q;
                            X_SHR: begin c_d = acc_q[0]; acc_d = {1'b0, acc_q[3:1]}; end
                            X_SUB: begin c_d = sub5[4]; acc_d = sub5[3:0]; end
                            X_DEC: begin c_d = dec5[4]; acc_d = dec5[3:0]; end
                            X_TST: t_d = (acc_q != 4'd0);
                            X_JMP: pc_d = lr_q;
                            X_SA:  ra_d = {ra_q[11:0], acc_q};
                            X_RSA: begin acc_d = ra_q[3:0]; ra_d = {ra_q[3:0], ra_q[15:4]}; end
`ifdef MISAO_WFI_EN
                            X_WFI: state_d = S_HALT;
`endif
                            default: ;
                        endcase
                    end
                end else if (phase_q == 2'd1) begin
                    // Operand nibble of a pending two/three-nibble instruction
                    phase_d = 2'd0;
                    case ({opx_q, op_q})
                        {1'b0, OP_LDI}:  acc_d = nib;
                        {1'b0, OP_BEQZ}: if (acc_q == 4'd0) pc_d = pc_br;
                        {1'b0, OP_BTST}: if (t_q) pc_d = pc_br;
                        {1'b0, OP_JAL}:  begin hi_d = nib; phase_d = 2'd2; end
                        {1'b1, X_CFG}:   cfg_d = nib;
                        {1'b1, X_BC}:    if (c_q) pc_d = pc_br;
                        default: ;
                    endcase
                end else begin
                    phase_d = 2'd0;
                    lr_d    = pc_inc;
                    pc_d    = pc_jal;
                end
            end
            S_STORE: state_d = S_FETCH;
`ifdef MISAO_WFI_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ra_q    <= 16'd0;
            lr_q    <= 16'd0;
            acc_q   <= 4'd0;
            rs_q    <= 4'd0;
            cfg_q   <= 4'd0;
            c_q     <= 1'b0;
            t_q     <= 1'b0;
            xop_q   <= 1'b0;
            phase_q <= 2'd0;
            op_q    <= 4'd0;
            opx_q   <= 1'b0;
            hi_q    <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 15'd0;
            dout_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            lr_q    <= lr_d;
            acc_q   <= acc_d;
            rs_q    <= rs_d;
            cfg_q   <= cfg_d;
            c_q     <= c_d;
            t_q     <= t_d;
            xop_q   <= xop_d;
            phase_q <= phase_d;
            op_q    <= op_d;
            opx_q   <= opx_d;
            hi_q    <= hi_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    assign mem_enable_read  = rd_q;
    assign mem_enable_write = wr_q;
    assign mem_rw           = rw_q;
    assign mem_addr         = addr_q;
    assign mem_data_out     = dout_q;
    assign test_data        = {2'b00, t_q, c_q, cfg_q, rs_q, acc_q};

endmodule

// File: tb/tb_misao_core.sv
// Bench for misao_core: directed programs plus random memory images against an instruction-level model.
module tb_misao_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enable_read, mem_enable_write, mem_rw;
    logic [7:0]  mem_data_in = 8'd0;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic [15:0] test_data;

    always #5 clk = ~clk;

    misao_core #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
        .mem_data_in(mem_data_in), .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_data_out(mem_data_out), .test_data(test_data)
    );

    logic [7:0] mem  [32768];
    logic [7:0] img  [32768];
    logic [7:0] mmem [32768];
    logic [7:0] prog [$];
    logic       load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 32768; i++) mem[i] <= img[i];
        end else if (mem_enable_write && mem_rw) begin
            mem[mem_addr] <= mem_data_out;
        end
        if (mem_enable_read) mem_data_in <= mem[mem_addr];
    end

    int          rd_cnt = 0, wr_cnt = 0, rw_bad = 0, both_cnt = 0;
    logic [31:0] wsig = 32'd0;
    logic [14:0] last_waddr = 15'd0;
    logic [7:0]  last_wdata = 8'd0;

    always @(negedge clk) begin
        if (mem_enable_read) rd_cnt++;
        if (mem_enable_write) begin
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_data_out;
            wsig = wsig * 32'd33 + {17'd0, mem_addr, mem_data_out};
        end
        if (mem_rw != mem_enable_write) rw_bad++;
        if (mem_enable_read && mem_enable_write) both_cnt++;
    end

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_prog();
        for (int i = 0; i < 32768; i++) img[i] = 8'd0;
        for (int i = 0; i < prog.size(); i++) img[i] = prog[i];
    endtask

    // Hold reset, load memory, check reset outputs, release; cyc counts posedges after release
    task automatic start();
        @(negedge clk); rst = 1'b0; load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        @(negedge clk); #1;
        chk("rst_test_data", 32'(test_data), 32'h0);
        chk("rst_strobes", 32'({mem_enable_read, mem_enable_write, mem_rw}), 32'h0);
        chk("rst_addr_dout", 32'({mem_addr, mem_data_out}), 32'h0);
        @(negedge clk); rst = 1'b1; cyc = 0;
    endtask

    task automatic run_to(input int b);
        while (cyc < b) begin @(posedge clk); cyc++; end
        @(negedge clk); #1;
    endtask

    // Instruction-level reference model
    typedef struct {
        logic [15:0] pc, ra, lr;
        logic [3:0]  acc, rs, cfg;
        logic        c, t, xop, halted, wr;
        logic [14:0] waddr;
        logic [7:0]  wdata;
        int          cost;
    } ms_t;

    function automatic logic [3:0] m_nib(input logic [15:0] a);
        logic [7:0] b;
        b = mmem[a[15:1]];
        return a[0] ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [15:0] m_rel(input logic [15:0] pc, input int off);
        return 16'((int'(pc) + off + 65536) % 65536);
    endfunction

    function automatic int sx4(input logic [3:0] v);
        return (int'(v) >= 8) ? int'(v) - 16 : int'(v);
    endfunction

    function automatic ms_t m_step(input ms_t s);
        ms_t n;
        int nibs, v, off;
        logic [3:0] op, o1, o2;
        logic br, cond;
        n = s; n.wr = 1'b0; nibs = 1; br = 1'b0; cond = 1'b0;
        op = m_nib(s.pc);
        n.pc = s.pc + 16'd1;
        if (s.xop) begin
            n.xop = 1'b0;
            case (op)
                4'h1: begin n.cfg = m_nib(n.pc); n.pc = n.pc + 16'd1; nibs = 2; end
                4'h5: n.acc = ~s.acc;
                4'h9: n.acc = s.acc ^ s.rs;
                4'hD: begin n.c = s.acc[0]; n.acc = 4'(int'(s.acc) / 2); end
                4'h3: begin v = int'(s.acc) - int'(s.rs); n.c = (v < 0); n.acc = 4'((v + 16) % 16); end
                4'hB: begin v = int'(s.acc) - 1; n.c = (v < 0); n.acc = 4'((v + 16) % 16); end
                4'h7: begin br = 1'b1; cond = s.c; end
                4'hF: n.t = (s.acc != 4'd0);
                4'h2: n.pc = s.lr;
                4'hE: n.ra = 16'((int'(s.ra) * 16 + int'(s.acc)) % 65536);
                4'hA: begin
                    n.acc = 4'(int'(s.ra) % 16);
                    n.ra  = 16'(int'(s.ra) / 16 + (int'(s.ra) % 16) * 4096);
                end
`ifdef MISAO_WFI_EN
                4'h0: n.halted = 1'b1;
`endif
                default: ;
            endcase
        end else begin
            case (op)
                4'h1: n.c = 1'b0;
                4'h5: n.acc = s.acc & s.rs;
                4'h9: n.acc = s.acc | s.rs;
                4'hD: begin n.c = s.acc[3]; n.acc = 4'((int'(s.acc) * 2) % 16); end
                4'h3: begin v = int'(s.acc) + int'(s.rs) + int'(s.c); n.c = (v > 15); n.acc = 4'(v % 16); end
                4'hB: begin v = int'(s.acc) + 1; n.c = (v > 15); n.acc = 4'(v % 16); end
                4'h7: begin br = 1'b1; cond = (s.acc == 4'd0); end
                4'hF: begin br = 1'b1; cond = s.t; end
                4'h2: begin
                    o1 = m_nib(n.pc); o2 = m_nib(n.pc + 16'd1);
                    n.pc = n.pc + 16'd2; nibs = 3;
                    n.lr = n.pc;
                    off = int'({o1, o2});
                    if (off >= 128) off = off - 256;
                    n.pc = m_rel(n.pc, off);
                end
                4'h6: begin n.acc = s.rs; n.rs = s.acc; end
                4'hA: n.acc = s.rs;
                4'hE: n.rs = s.acc;
                4'h4: begin n.acc = m_nib(n.pc); n.pc = n.pc + 16'd1; nibs = 2; end
                4'hC: begin n.wr = 1'b1; n.waddr = s.ra[15:1]; n.wdata = {s.rs, s.acc}; end
                4'h8: n.xop = 1'b1;
                default: ;
            endcase
        end
        if (br) begin
            o1 = m_nib(n.pc); n.pc = n.pc + 16'd1; nibs = 2;
            if (cond) n.pc = m_rel(n.pc, sx4(o1));
        end
        n.cost = 3 * nibs + (n.wr ? 1 : 0);
        return n;
    endfunction

    function automatic logic [15:0] vis(input ms_t s);
        return {2'b00, s.t, s.c, s.cfg, s.rs, s.acc};
    endfunction

    ms_t         ms, pend;
    int          cum, b_pt, m_wr, e_wr, w0, r0;
    logic [31:0] m_sig, e_sig;

    initial begin
        // LDI 5, then reset clears it
        prog = {8'h54}; set_prog(); start();
        run_to(6);  chk("ldi_td", 32'(test_data), 32'h0005);
        run_to(7);  chk("ldi_pc_fetch", 32'({mem_enable_read, mem_addr}), 32'({1'b1, 15'd1}));
        start();

        // Branches: BEQZ taken skips LDI F, second BEQZ falls through
        prog = {8'h18, 8'h0C, 8'h04, 8'h27, 8'hF4, 8'hA4, 8'h14, 8'h27, 8'h54, 8'h00};
        set_prog(); start();
        run_to(30); chk("br_taken", 32'(test_data), 32'h0C0A);
        run_to(48); chk("br_final", 32'(test_data), 32'h0C05);

        // ADD with carry, CC, extended SUB with borrow
        prog = {8'h94, 8'h4E, 8'h38, 8'h81, 8'h03}; set_prog(); start();
        run_to(18); chk("add_carry", 32'(test_data), 32'h1091);
        run_to(21); chk("cc", 32'(test_data), 32'h0091);
        run_to(27); chk("sub_borrow", 32'(test_data), 32'h1098);

        // XOP CFG C, then LDI 7 must decode on the base page
        prog = {8'h18, 8'h4C, 8'h07}; set_prog(); start();
        run_to(15); chk("cfg_then_base", 32'(test_data), 32'h0C07);

        // SA / SS / XMEM single write of 0x67 to byte 1
        prog = {8'h34, 8'hE8, 8'h64, 8'h4E, 8'hC7}; set_prog(); start();
        w0 = wr_cnt;
        run_to(40);
        chk("xmem_count", 32'(wr_cnt - w0), 32'd1);
        chk("xmem_addr_data", 32'({last_waddr, last_wdata}), 32'({15'd1, 8'h67}));

        // JAL +4 skips LDI 6; XOP JMP returns to it
        prog = {8'h02, 8'h44, 8'h06, 8'h80, 8'h02}; set_prog(); start();
        run_to(10); chk("jal_target_fetch", 32'(mem_addr), 32'd3);
        run_to(15); chk("jal_skipped", 32'(test_data), 32'h0000);
        run_to(16); chk("jmp_fetch", 32'(mem_addr), 32'd1);
        run_to(21); chk("jmp_return", 32'(test_data), 32'h0006);

        // XOP WFI followed by LDI 5
        prog = {8'h08, 8'h54}; set_prog(); start();
`ifdef MISAO_WFI_EN
        run_to(6); r0 = rd_cnt;
        run_to(26);
        chk("wfi_no_reads", 32'(rd_cnt - r0), 32'd0);
        chk("wfi_hold", 32'(test_data), 32'h0000);
`else
        run_to(12); chk("wfi_as_nop", 32'(test_data), 32'h0005);
`endif

        // Random memory images against the model, sampled at random cycle points
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32768; i++) begin
                img[i]  = 8'($urandom);
                mmem[i] = img[i];
            end
            start();
            ms.pc = 16'h0000; ms.ra = 16'd0; ms.lr = 16'd0;
            ms.acc = 4'd0; ms.rs = 4'd0; ms.cfg = 4'd0;
            ms.c = 1'b0; ms.t = 1'b0; ms.xop = 1'b0; ms.halted = 1'b0; ms.wr = 1'b0;
            ms.waddr = 15'd0; ms.wdata = 8'd0; ms.cost = 0;
            pend = m_step(ms);
            cum = 0; m_wr = 0; w0 = wr_cnt; m_sig = wsig; b_pt = 0;
            while (b_pt < 600) begin
                b_pt += int'($urandom_range(5, 40));
                while (!ms.halted && cum + pend.cost <= b_pt) begin
                    cum += pend.cost;
                    ms = pend;
                    if (ms.wr) begin
                        mmem[ms.waddr] = ms.wdata;
                        m_wr++;
                        m_sig = m_sig * 32'd33 + {17'd0, ms.waddr, ms.wdata};
                    end
                    if (!ms.halted) pend = m_step(ms);
                end
                e_wr = m_wr; e_sig = m_sig;
                if (!ms.halted && pend.wr && cum + pend.cost - 1 <= b_pt) begin
                    e_wr++;
                    e_sig = e_sig * 32'd33 + {17'd0, pend.waddr, pend.wdata};
                end
                run_to(b_pt);
                chk("rnd_state", 32'(test_data), 32'(vis(ms)));
                chk("rnd_wr_count", 32'(wr_cnt - w0), 32'(e_wr));
                chk("rnd_wr_sig", wsig, e_sig);
            end
        end

        chk("strobe_overlap", 32'(both_cnt), 32'd0);
        chk("rw_without_write", 32'(rw_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
